vector_stager: RTL and testbench

- Owns the D-entry fixed-point vector memory that a function unit (e.g. RMS norm) uses as its working buffer.
- Responds on the FU memory port: FU drives address, write enable and write data; this block returns read data.
- Initiates FU operations over the in_ready/in_start handshake.
- Fills the buffer from an upstream valid/ready stream, starts the FU, waits for completion, then drains the result to a downstream valid/ready stream.

---
 rtl/vector_stager_if.sv | 32 +++
 rtl/vector_stager.sv | 91 +++++++++
 tb/tb_vector_stager.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_stager_if.sv
// Bundles the stream, FU-handshake and FU-memory signals of vector_stager.
// The stager owns the slave side; the surrounding logic owns the master side.
interface vector_stager_if #(
  parameter int unsigned D = 8,
  parameter int unsigned W = 16
);
  localparam int unsigned AW = $clog2(D);

  logic          s_valid_i;
  logic          s_ready_o;
  logic [W-1:0]  s_data_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [W-1:0]  m_data_o;
  logic          fu_ready_i;
  logic          fu_start_o;
  logic [AW-1:0] fu_addr_i;
  logic          fu_w_en_i;
  logic [W-1:0]  fu_w_data_i;
  logic [W-1:0]  fu_r_data_o;
  logic          busy_o;

  modport master (
    output s_valid_i, s_data_i, m_ready_i, fu_ready_i, fu_addr_i, fu_w_en_i, fu_w_data_i,
    input  s_ready_o, m_valid_o, m_data_o, fu_start_o, fu_r_data_o, busy_o
  );

  modport slave (
    input  s_valid_i, s_data_i, m_ready_i, fu_ready_i, fu_addr_i, fu_w_en_i, fu_w_data_i,
    output s_ready_o, m_valid_o, m_data_o, fu_start_o, fu_r_data_o, busy_o
  );
endinterface

// File: rtl/vector_stager.sv
// Single-buffer vector stager: fills D entries from upstream, runs the FU on
// them in place, then drains the result downstream.
module vector_stager #(
  parameter int unsigned D = 8,
  parameter int unsigned W = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  vector_stager_if.slave bus
);
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {FILL, START, BUSY, DRAIN} state_e;

  state_e        state_q;
  logic [CW-1:0] wr_cnt_q;
  logic [CW-1:0] rd_cnt_q;
  logic          first_q;
  logic [W-1:0]  mem [D];

  logic s_fire;
  logic m_fire;

  assign s_fire = (state_q == FILL) && bus.s_valid_i;
  assign m_fire = (state_q == DRAIN) && bus.m_ready_i;

  // Control: phase sequencing and fill/drain counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      first_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_fire) begin
            if (wr_cnt_q == CW'(D - 1)) begin
              wr_cnt_q <= '0;
              state_q  <= START;
            end else begin
              wr_cnt_q <= wr_cnt_q + CW'(1);
            end
          end
        end
        START: begin
          if (bus.fu_ready_i) begin
            state_q <= BUSY;
            first_q <= 1'b1;
          end
        end
        BUSY: begin
          // The ready seen in the first BUSY cycle may predate our start.
          if (first_q) begin
            first_q <= 1'b0;
          end else if (bus.fu_ready_i) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_fire) begin
            if (rd_cnt_q == CW'(D - 1)) begin
              rd_cnt_q <= '0;
              state_q  <= FILL;
            end else begin
              rd_cnt_q <= rd_cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Storage is written by the upstream stream in FILL and by the FU in BUSY.
  always_ff @(posedge clk_i) begin
    if (s_fire) begin
      mem[wr_cnt_q[AW-1:0]] <= bus.s_data_i;
    end else if ((state_q == BUSY) && bus.fu_w_en_i) begin
      mem[bus.fu_addr_i] <= bus.fu_w_data_i;
    end
  end

  assign bus.s_ready_o   = (state_q == FILL);
  assign bus.m_valid_o   = (state_q == DRAIN);
  assign bus.m_data_o    = mem[rd_cnt_q[AW-1:0]];
  assign bus.fu_start_o  = (state_q == START) && bus.fu_ready_i;
  assign bus.busy_o      = (state_q != FILL);
  assign bus.fu_r_data_o = mem[bus.fu_addr_i];
endmodule

// File: tb/tb_vector_stager.sv
// Self-checking bench for vector_stager: directed table/sequence checks plus
// randomized fill/FU/drain transactions against an array model.
module tb_vector_stager;
  localparam int unsigned D  = 8;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = $clog2(D);

  logic clk_i;
  logic rst_ni;

  vector_stager_if #(.D(D), .W(W)) bus ();

  vector_stager #(.D(D), .W(W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int tests;
  int fails;

  // Expected buffer contents: what the stream wrote, overlaid by FU writes.
  logic [W-1:0] model [D];

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [W-1:0]  wdata;
    logic [W-1:0]  exp_r;
  } fu_vec_t;

  fu_vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_valid_i   = 1'b0;
    bus.s_data_i    = '0;
    bus.m_ready_i   = 1'b0;
    bus.fu_ready_i  = 1'b0;
    bus.fu_addr_i   = '0;
    bus.fu_w_en_i   = 1'b0;
    bus.fu_w_data_i = '0;
  endtask

  // Stream model[] in with random valid gaps.
  task automatic fill_model();
    int beats;
    beats = 0;
    for (int cyc = 0; cyc < 400 && beats < int'(D); cyc++) begin
      bus.s_valid_i = ($urandom % 4) != 0;
      bus.s_data_i  = model[beats];
      #1;
      chk("fill_ready", 32'(bus.s_ready_o), 32'd1);
      if (bus.s_valid_i) beats++;
      tick();
    end
    bus.s_valid_i = 1'b0;
    chk("fill_count", 32'(beats), 32'(D));
  endtask

  // Start the FU after a random delay, apply nwr random FU writes, then finish.
  task automatic run_fu(input int nwr);
    int dly;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    dly = int'($urandom % 4);
    for (int i = 0; i < dly; i++) begin
      bus.fu_ready_i = 1'b0;
      #1;
      chk("start_wait", 32'(bus.fu_start_o), 32'd0);
      tick();
    end
    bus.fu_ready_i = 1'b1;
    #1;
    chk("start_pulse", 32'(bus.fu_start_o), 32'd1);
    tick();
    bus.fu_ready_i = 1'b0;
    for (int i = 0; i < nwr; i++) begin
      a = AW'($urandom % D);
      d = W'($urandom);
      bus.fu_addr_i   = a;
      bus.fu_w_en_i   = 1'b1;
      bus.fu_w_data_i = d;
      #1;
      chk("fu_rd", 32'(bus.fu_r_data_o), 32'(model[a]));
      tick();
      model[a] = d;
    end
    bus.fu_w_en_i  = 1'b0;
    bus.fu_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.m_valid_o) break;
      tick();
    end
    bus.fu_ready_i = 1'b0;
    chk("drain_start", 32'(bus.m_valid_o), 32'd1);
  endtask

  // Accept n beats with random backpressure and compare against model[].
  task automatic drain(input int n);
    int beats;
    beats = 0;
    for (int cyc = 0; cyc < 400 && beats < n; cyc++) begin
      bus.m_ready_i = $urandom_range(0, 1) == 1;
      #1;
      chk("drain_valid", 32'(bus.m_valid_o), 32'd1);
      if (bus.m_ready_i) begin
        chk("drain_data", 32'(bus.m_data_o), 32'(model[beats]));
        beats++;
      end
      tick();
    end
    bus.m_ready_i = 1'b0;
    chk("drain_count", 32'(beats), 32'(n));
  endtask

  initial begin
    logic [W-1:0] exp_d [D];
    logic         pat [4];
    logic [W-1:0] prev_d;
    logic         prev_stall;
    int           beats;

    tests = 0;
    fails = 0;
    tbl[0] = '{addr: AW'(3), we: 1'b0, wdata: W'(0),    exp_r: W'(4)};
    tbl[1] = '{addr: AW'(3), we: 1'b1, wdata: W'(7),    exp_r: W'(4)};
    tbl[2] = '{addr: AW'(3), we: 1'b0, wdata: W'(0),    exp_r: W'(7)};
    tbl[3] = '{addr: AW'(0), we: 1'b0, wdata: W'(0),    exp_r: W'(1)};
    tbl[4] = '{addr: AW'(7), we: 1'b0, wdata: W'(0),    exp_r: W'(8)};
    tbl[5] = '{addr: AW'(5), we: 1'b1, wdata: W'(16'h55), exp_r: W'(6)};
    tbl[6] = '{addr: AW'(5), we: 1'b1, wdata: W'(6),    exp_r: W'(16'h55)};
    tbl[7] = '{addr: AW'(5), we: 1'b0, wdata: W'(0),    exp_r: W'(6)};
    for (int k = 0; k < int'(D); k++) exp_d[k] = W'(k + 1);
    exp_d[3] = W'(7);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;

    // Idle after reset, with a ready FU that must not be started.
    bus.fu_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_s_ready", 32'(bus.s_ready_o), 32'd1);
      chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
      chk("rst_fu_start", 32'(bus.fu_start_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      tick();
    end
    bus.fu_ready_i = 1'b0;

    // Back-to-back fill of k+1.
    for (int k = 0; k < int'(D); k++) begin
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = W'(k + 1);
      #1;
      chk("dir_fill_ready", 32'(bus.s_ready_o), 32'd1);
      tick();
    end
    bus.s_data_i = W'(16'hdead);
    #1;
    chk("dir_ready_drop", 32'(bus.s_ready_o), 32'd0);
    bus.s_valid_i = 1'b0;

    for (int i = 0; i < 5; i++) begin
      #1;
      chk("dir_start_hold", 32'(bus.fu_start_o), 32'd0);
      chk("dir_start_busy", 32'(bus.busy_o), 32'd1);
      tick();
    end
    bus.fu_ready_i = 1'b1;
    #1;
    chk("dir_start_pulse", 32'(bus.fu_start_o), 32'd1);
    tick();
    #1;
    chk("dir_start_once", 32'(bus.fu_start_o), 32'd0);
    chk("dir_busy1_no_drain", 32'(bus.m_valid_o), 32'd0);
    tick();
    bus.fu_ready_i = 1'b0;
    #1;
    chk("dir_stale_ready", 32'(bus.m_valid_o), 32'd0);

    // FU memory port vectors while BUSY.
    for (int i = 0; i < 8; i++) begin
      bus.fu_addr_i   = tbl[i].addr;
      bus.fu_w_en_i   = tbl[i].we;
      bus.fu_w_data_i = tbl[i].wdata;
      #1;
      chk($sformatf("tbl_rd%0d", i), 32'(bus.fu_r_data_o), 32'(tbl[i].exp_r));
      tick();
    end
    bus.fu_w_en_i  = 1'b0;
    bus.fu_ready_i = 1'b1;
    tick();
    bus.fu_ready_i = 1'b0;

    // Drain with ready pattern 1,0,0,1; data must hold while stalled.
    beats = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    for (int cyc = 0; cyc < 64 && beats < int'(D); cyc++) begin
      bus.m_ready_i = pat[cyc % 4];
      #1;
      chk("dir_drain_valid", 32'(bus.m_valid_o), 32'd1);
      if (prev_stall) chk("dir_drain_hold", 32'(bus.m_data_o), 32'(prev_d));
      if (bus.m_ready_i) begin
        chk($sformatf("dir_drain%0d", beats), 32'(bus.m_data_o), 32'(exp_d[beats]));
        beats++;
      end
      prev_d = bus.m_data_o;
      prev_stall = !bus.m_ready_i;
      tick();
    end
    bus.m_ready_i = 1'b0;
    chk("dir_drain_count", 32'(beats), 32'(D));
    #1;
    chk("dir_back_fill", 32'(bus.s_ready_o), 32'd1);
    chk("dir_back_mvalid", 32'(bus.m_valid_o), 32'd0);
    tick();

    // Reset during drain, then a complete new transaction.
    for (int k = 0; k < int'(D); k++) model[k] = W'($urandom);
    fill_model();
    run_fu(0);
    drain(2);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    chk("mid_rst_s_ready", 32'(bus.s_ready_o), 32'd1);
    chk("mid_rst_m_valid", 32'(bus.m_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    tick();
    for (int k = 0; k < int'(D); k++) model[k] = W'($urandom);
    fill_model();
    run_fu(2);
    drain(int'(D));

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < int'(D); k++) model[k] = W'($urandom);
      fill_model();
      run_fu(int'($urandom % 5));
      drain(int'(D));
      #1;
      chk("rand_back_fill", 32'(bus.s_ready_o), 32'd1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
